// File: rtl/fpu_addsub_param.sv
// fpu_addsub_param: parametrised IEEE-754 adder/subtractor, fixed latency.
// Pipeline of one state per cycle: IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, OUT.
// NaN/Inf operands skip from UNPACK straight to OUT.
// Ports:
//   clk, rst (async, active low)
//   input_a, input_b, input_op (0 add, 1 sub), input_stb / input_ack
//   output_z, output_flags {invalid, overflow, underflow, inexact},
//   output_z_stb / output_z_ack
module fpu_addsub_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] input_a,
  input  logic [W-1:0] input_b,
  input  logic         input_op,
  input  logic         input_stb,
  output logic         input_ack,
  output logic [W-1:0] output_z,
  output logic [3:0]   output_flags,
  output logic         output_z_stb,
  input  logic         output_z_ack
);

  // Significand layout: {hidden, fraction, guard, round, sticky}
  localparam int SW     = MAN_W + 4;
  localparam int XW     = EXP_W + 1;
  localparam int SH_MAX = MAN_W + 3;
  localparam logic [XW-1:0] EXP_INF = {1'b0, {EXP_W{1'b1}}};
  localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, OUT} state_t;

  state_t state, next_state;

  logic [W-1:0]     a_q, b_q;
  logic             sign_big, sub_q, res_sign;
  logic [EXP_W-1:0] exp_big, diff;
  logic [SW-1:0]    sig_big, sig_small, norm_sig;
  logic [SW:0]      sum_q;
  logic [XW-1:0]    norm_exp;

  // Operand classification
  logic             sa, sb;
  logic [EXP_W-1:0] ea_f, eb_f, ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0]   ma, mb;
  logic             a_spec, b_spec, a_nan, b_nan, a_snan, b_snan, a_bigger;

  assign {sa, ea_f, fa} = a_q;
  assign {sb, eb_f, fb} = b_q;
  assign a_spec   = &ea_f;
  assign b_spec   = &eb_f;
  assign a_nan    = a_spec & (|fa);
  assign b_nan    = b_spec & (|fb);
  assign a_snan   = a_nan & ~fa[MAN_W-1];
  assign b_snan   = b_nan & ~fb[MAN_W-1];
  // Denormals use effective exponent 1 with a zero hidden bit
  assign ea       = (ea_f == '0) ? {{(EXP_W-1){1'b0}}, 1'b1} : ea_f;
  assign eb       = (eb_f == '0) ? {{(EXP_W-1){1'b0}}, 1'b1} : eb_f;
  assign ma       = {|ea_f, fa};
  assign mb       = {|eb_f, fb};
  assign a_bigger = {ea, ma} >= {eb, mb};

  logic [W-1:0] spec_z;
  logic [3:0]   spec_flags;

  always_comb begin
    spec_z     = '0;
    spec_flags = '0;
    if (a_nan || b_nan) begin
      spec_z        = QNAN;
      spec_flags[3] = a_snan | b_snan;
    end else if (a_spec && b_spec && (sa != sb)) begin
      spec_z        = QNAN;
      spec_flags[3] = 1'b1;
    end else if (a_spec) begin
      spec_z = a_q;
    end else if (b_spec) begin
      spec_z = b_q;
    end
  end

  // Alignment: bits pushed below the sticky slot are folded into it
  logic [31:0]   sh;
  logic [SW-1:0] shifted, lost_mask, aligned;

  always_comb begin
    sh        = (32'(diff) > 32'(SH_MAX)) ? 32'(SH_MAX) : 32'(diff);
    shifted   = sig_small >> sh;
    lost_mask = (SW'(1) << sh) - SW'(1);
    aligned   = {shifted[SW-1:1], shifted[0] | (|(sig_small & lost_mask))};
  end

  logic [SW:0] sum_d;
  assign sum_d = sub_q ? ({1'b0, sig_big} - {1'b0, sig_small})
                       : ({1'b0, sig_big} + {1'b0, sig_small});

  // Normalisation: left shift is clamped so the exponent stays >= 1,
  // which leaves tiny results as denormals with a zero hidden bit
  logic [31:0]   lzc, lim, lsh;
  logic [SW-1:0] norm_sig_d;
  logic [XW-1:0] norm_exp_d;

  always_comb begin
    lzc = 32'(SW);
    for (int i = 0; i < SW; i++) begin
      if (sum_q[i]) lzc = 32'(SW - 1 - i);
    end
    lim = 32'(exp_big) - 32'd1;
    lsh = (lzc < lim) ? lzc : lim;
    if (sum_q[SW]) begin
      norm_sig_d = {sum_q[SW:2], sum_q[1] | sum_q[0]};
      norm_exp_d = {1'b0, exp_big} + XW'(1);
    end else begin
      norm_sig_d = sum_q[SW-1:0] << lsh;
      norm_exp_d = {1'b0, exp_big} - XW'(lsh);
    end
  end

  logic [MAN_W:0]   mant;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] frac_r;
  logic [XW-1:0]    exp_r;
  logic             inexact, round_up, hidden;
  logic [W-1:0]     round_z;
  logic [3:0]       round_flags;

  always_comb begin
    mant     = norm_sig[SW-1:3];
    inexact  = |norm_sig[2:0];
    round_up = norm_sig[2] & (norm_sig[1] | norm_sig[0] | mant[0]);
    mant_r   = {1'b0, mant} + {{(MAN_W+1){1'b0}}, round_up};
    if (mant_r[MAN_W+1]) begin
      exp_r  = norm_exp + XW'(1);
      frac_r = mant_r[MAN_W:1];
      hidden = 1'b1;
    end else begin
      exp_r  = norm_exp;
      frac_r = mant_r[MAN_W-1:0];
      hidden = mant_r[MAN_W];
    end
    round_z     = {res_sign, (hidden ? exp_r[EXP_W-1:0] : {EXP_W{1'b0}}), frac_r};
    round_flags = {2'b00, ~hidden & inexact, inexact};
    if (hidden && (exp_r >= EXP_INF)) begin
      round_z     = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      round_flags = 4'b0101;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (input_stb && input_ack) next_state = UNPACK;
      UNPACK:  next_state = (a_spec || b_spec) ? OUT : ALIGN;
      ALIGN:   next_state = ADD;
      ADD:     next_state = NORM;
      NORM:    next_state = ROUND;
      ROUND:   next_state = OUT;
      OUT:     if (output_z_ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // input_ack is registered so it stays low for the first edge after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      input_ack <= 1'b0;
    end else begin
      state     <= next_state;
      input_ack <= (next_state == IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q          <= '0;
      b_q          <= '0;
      sign_big     <= 1'b0;
      sub_q        <= 1'b0;
      res_sign     <= 1'b0;
      exp_big      <= '0;
      diff         <= '0;
      sig_big      <= '0;
      sig_small    <= '0;
      sum_q        <= '0;
      norm_sig     <= '0;
      norm_exp     <= '0;
      output_z     <= '0;
      output_flags <= '0;
      output_z_stb <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (input_stb && input_ack) begin
            a_q <= input_a;
            b_q <= {input_b[W-1] ^ input_op, input_b[W-2:0]};
          end
        end
        UNPACK: begin
          if (a_spec || b_spec) begin
            output_z     <= spec_z;
            output_flags <= spec_flags;
            output_z_stb <= 1'b1;
          end
          sub_q <= sa ^ sb;
          if (a_bigger) begin
            sign_big  <= sa;
            exp_big   <= ea;
            diff      <= ea - eb;
            sig_big   <= {ma, 3'b000};
            sig_small <= {mb, 3'b000};
          end else begin
            sign_big  <= sb;
            exp_big   <= eb;
            diff      <= eb - ea;
            sig_big   <= {mb, 3'b000};
            sig_small <= {ma, 3'b000};
          end
        end
        ALIGN: sig_small <= aligned;
        ADD: begin
          sum_q    <= sum_d;
          // Exact cancellation gives +0; equal-sign zeros keep their sign
          res_sign <= (sub_q && (sum_d == '0)) ? 1'b0 : sign_big;
        end
        NORM: begin
          norm_sig <= norm_sig_d;
          norm_exp <= norm_exp_d;
        end
        ROUND: begin
          output_z     <= round_z;
          output_flags <= round_flags;
          output_z_stb <= 1'b1;
        end
        OUT: if (output_z_ack) output_z_stb <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub_param.sv
// Scoreboard bench for fpu_addsub_param: single-precision and half-precision
// instances share clock and reset; expected results are queued at accept time
// and popped by per-instance monitors when output_z_stb rises.
module tb_fpu_addsub_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = '0, input_b = '0;
  logic        input_op = 1'b0, input_stb = 1'b0;
  logic        input_ack;
  logic [31:0] output_z;
  logic [3:0]  output_flags;
  logic        output_z_stb, output_z_ack;
  logic        hold = 1'b0;

  logic [15:0] h_a = '0, h_b = '0;
  logic        h_op = 1'b0, h_stb = 1'b0;
  logic        h_in_ack;
  logic [15:0] h_z;
  logic [3:0]  h_flags;
  logic        h_z_stb, h_z_ack;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] z;
    logic [3:0]  f;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q_full[$];
  exp_t q_half[$];
  exp_t mon_f, mon_h;
  bit   seen_f = 1'b0, seen_h = 1'b0;

  assign output_z_ack = ~hold;
  assign h_z_ack      = 1'b1;

  fpu_addsub_param dut (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_b(input_b), .input_op(input_op),
    .input_stb(input_stb), .input_ack(input_ack),
    .output_z(output_z), .output_flags(output_flags),
    .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
  );

  fpu_addsub_param #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst),
    .input_a(h_a), .input_b(h_b), .input_op(h_op),
    .input_stb(h_stb), .input_ack(h_in_ack),
    .output_z(h_z), .output_flags(h_flags),
    .output_z_stb(h_z_stb), .output_z_ack(h_z_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit half, input logic [31:0] a, input logic [31:0] b,
                               input logic op, input logic [31:0] ez, input logic [3:0] ef,
                               input int lat);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!(half ? h_in_ack : input_ack) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(half ? h_in_ack : input_ack)) begin
      checkOutput("input_ack wait", 32'(half ? h_in_ack : input_ack), 32'd1);
      return;
    end
    if (half) begin
      h_a = a[15:0]; h_b = b[15:0]; h_op = op; h_stb = 1'b1;
    end else begin
      input_a = a; input_b = b; input_op = op; input_stb = 1'b1;
    end
    @(posedge clk);
    #1;
    e.z = ez; e.f = ef; e.lat = lat; e.acc = cyc;
    if (half) q_half.push_back(e);
    else      q_full.push_back(e);
    h_stb     = 1'b0;
    input_stb = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((q_full.size() != 0 || q_half.size() != 0 || output_z_stb || h_z_stb) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(q_full.size() + q_half.size()), 32'd0);
  endtask

  initial begin : monitor_full
    forever begin
      @(negedge clk);
      if (!output_z_stb) seen_f = 1'b0;
      else if (!seen_f) begin
        seen_f = 1'b1;
        if (q_full.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected output: got z 0x%0h with nothing expected", output_z);
        end else begin
          mon_f = q_full.pop_front();
          checkOutput("sp z", output_z, mon_f.z);
          checkOutput("sp flags", 32'(output_flags), 32'(mon_f.f));
          checkOutput("sp latency", 32'(cyc - mon_f.acc), 32'(mon_f.lat));
        end
      end
    end
  end

  initial begin : monitor_half
    forever begin
      @(negedge clk);
      if (!h_z_stb) seen_h = 1'b0;
      else if (!seen_h) begin
        seen_h = 1'b1;
        if (q_half.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected half output: got z 0x%0h with nothing expected", h_z);
        end else begin
          mon_h = q_half.pop_front();
          checkOutput("hp z", 32'(h_z), mon_h.z);
          checkOutput("hp flags", 32'(h_flags), 32'(mon_h.f));
          checkOutput("hp latency", 32'(cyc - mon_h.acc), 32'(mon_h.lat));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int n;
    #2 rst = 1'b0;
    #1;
    checkOutput("reset z", output_z, 32'd0);
    checkOutput("reset flags", 32'(output_flags), 32'd0);
    checkOutput("reset stb", 32'(output_z_stb), 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset ack", 32'(input_ack), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ack after release", 32'(input_ack), 32'd1);

    applyStimulus(0, 32'h3FC00000, 32'h40200000, 1'b0, 32'h40800000, 4'b0000, 5);
    applyStimulus(0, 32'hC0500000, 32'h3FE00000, 1'b0, 32'hBFC00000, 4'b0000, 5);
    applyStimulus(0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 5);
    applyStimulus(0, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 5);
    applyStimulus(0, 32'h40A00000, 32'h3F800000, 1'b1, 32'h40800000, 4'b0000, 5);
    applyStimulus(0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 5);
    applyStimulus(0, 32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001, 5);
    applyStimulus(0, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 5);
    applyStimulus(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 5);
    applyStimulus(0, 32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 4'b0000, 5);
    applyStimulus(0, 32'h00800001, 32'h00800000, 1'b1, 32'h00000001, 4'b0000, 5);
    applyStimulus(0, 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000, 1);
    applyStimulus(0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 1);
    applyStimulus(0, 32'h7F800000, 32'h40A00000, 1'b0, 32'h7F800000, 4'b0000, 1);
    applyStimulus(0, 32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 1);
    applyStimulus(0, 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 1);
    waitDrain();

    // Back-pressure: consumer stalls while a second operand pair is offered
    hold = 1'b1;
    applyStimulus(0, 32'h3FC00000, 32'h40200000, 1'b0, 32'h40800000, 4'b0000, 5);
    n = 0;
    while (!output_z_stb && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp stb rise", 32'(output_z_stb), 32'd1);
    input_a = 32'h3F800000; input_b = 32'h3F800000; input_op = 1'b0; input_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp z held", output_z, 32'h40800000);
      checkOutput("bp stb held", 32'(output_z_stb), 32'd1);
      checkOutput("bp ack low", 32'(input_ack), 32'd0);
    end
    input_stb = 1'b0;
    hold      = 1'b0;
    waitDrain();

    // Reset while the operation sits in ALIGN
    @(negedge clk);
    checkOutput("idle before reset op", 32'(input_ack), 32'd1);
    input_a = 32'h3FC00000; input_b = 32'h40200000; input_op = 1'b0; input_stb = 1'b1;
    @(posedge clk);
    #1 input_stb = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("mid reset z", output_z, 32'd0);
    checkOutput("mid reset flags", 32'(output_flags), 32'd0);
    checkOutput("mid reset stb", 32'(output_z_stb), 32'd0);
    checkOutput("mid reset ack", 32'(input_ack), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 32'hC0500000, 32'h3FE00000, 1'b0, 32'hBFC00000, 4'b0000, 5);

    // Half-precision instance
    applyStimulus(1, 32'h3C00, 32'h3C00, 1'b0, 32'h4000, 4'b0000, 5);
    applyStimulus(1, 32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 4'b0101, 5);
    applyStimulus(1, 32'h7C00, 32'hFC00, 1'b0, 32'h7E00, 4'b1000, 1);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_addsub_param.md
Name: fpu_addsub_param

Overview:
- Parametrised IEEE-754 floating-point adder/subtractor; next generation of the team's single-precision fpu_adder.
- Adds: configurable exponent/fraction widths, add/sub op select, two-sided valid/ack handshake with back-pressure, round-to-nearest-even, gradual underflow, exception flags, fixed latency.
- Sits in the matrix-multiply datapath as the accumulate unit after the FP multiplier.

Parameters:
- EXP_W, 8, exponent width in bits (≥3).
- MAN_W, 23, stored fraction width in bits (≥2).
- W = 1+EXP_W+MAN_W is a derived localparam, not overridable.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- input_a  in  W  operand A, IEEE format {sign, exp, frac}.
- input_b  in  W  operand B.
- input_op  in  1  0: Z=A+B; 1: Z=A−B (B sign inverted at capture).
- input_stb  in  1  operands valid.
- input_ack  out  1  block ready to accept operands.
- output_z  out  W  result.
- output_flags  out  4  {invalid, overflow, underflow, inexact}, valid with output_z.
- output_z_stb  out  1  result valid.
- output_z_ack  in  1  consumer accepts result.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; input_ack=0 while asserted, 1 on first edge after release; output_z=0, output_flags=0, output_z_stb=0. Any in-flight operation is discarded.
- Input transfer: on a rising edge with input_stb=1 and input_ack=1. input_ack=1 only in IDLE. Operands and op are latched at that edge, and input_ack drops after it.
- State sequence: IDLE→UNPACK→ALIGN→ADD→NORM→ROUND→OUT→IDLE, one state per cycle.
  - UNPACK: classify operands; restore hidden bit (0 for exp=0, effective exponent 1); NaN/Inf route directly to OUT.
  - ALIGN: single-cycle barrel right-shift of smaller-magnitude significand. Keep guard and round bits; OR all shifted-out bits into sticky. Shift amount saturates at MAN_W+3.
  - ADD: add or subtract magnitudes per effective sign; larger magnitude sets result sign.
  - NORM: single-cycle leading-zero count and left shift, or 1-bit right shift on carry-out. Left shift is limited so exponent never drops below 1 (denormal result).
  - ROUND: RNE on guard/round/sticky; mantissa overflow from rounding increments exponent.
- Output timing:
  - Normal operands: output_z/flags registered and output_z_stb=1 after the 5th rising edge following the accepting edge.
  - NaN/Inf operands: output after the 1st rising edge following the accepting edge.
- Output handshake: output_z, output_flags and output_z_stb are held stable while output_z_stb=1 and output_z_ack=0. On an edge with both high, output_z_stb clears and state returns to IDLE; input_ack=1 next cycle. output_z_ack while output_z_stb=0 is ignored.
- Special cases:
  - Any NaN operand → canonical NaN (sign 0, exp all ones, frac MSB 1, rest 0); invalid=1 only for signalling NaN.
  - +Inf plus −Inf (after op applied) → canonical NaN, invalid=1.
  - Inf plus finite → that Inf, flags 0.
  - Exact zero sum of opposite-sign operands → +0. (−0)+(−0) → −0.
- Overflow: rounded exponent ≥ all-ones → ±Inf; overflow=1, inexact=1.
- Underflow: set only when the result is tiny (exp=0) and inexact. An exact denormal result gives flags 0.
- inexact=1 whenever any of guard, round or sticky ≠ 0 before rounding.

Test Plan:
- Default params: A=0x3FC00000, B=0x40200000, op=0 → Z=0x40800000, flags=0, output_z_stb exactly 5 edges after accept.
- A=0xC0500000, B=0x3FE00000, op=0 → Z=0xBFC00000. A=0x3F800000, B=0x3F800000, op=1 → Z=0x00000000 (+0), flags=0.
- Rounding and limits:
  - A=0x3F800000, B=0x33800000 (tie) → Z=0x3F800000, flags=0001.
  - A=B=0x7F7FFFFF → Z=0x7F800000, flags=0101.
  - A=0x00000001, B=0x00000002 → Z=0x00000003, flags=0.
- Specials:
  - A=0x7F800000, B=0xFF800000, op=0 → Z=0x7FC00000, flags=1000, stb 1 edge after accept.
  - A=0x7F800000, B=0x40A00000 → Z=0x7F800000.
- Back-pressure/reset:
  - Hold output_z_ack=0 for 3 cycles → Z/stb stable, input_ack=0, new input_stb ignored.
  - Pull rst low during ALIGN → all outputs 0 immediately; next op completes normally.
- EXP_W=5, MAN_W=10 build: A=B=0x3C00, op=0 → Z=0x4000. A=0x7BFF, B=0x7BFF → Z=0x7C00, flags=0101.
